// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared encodings and decode helpers for the pipeline controller
package definitions;

    typedef enum logic [2:0] {
        NOP  = 3'b000,
        LD   = 3'b001,
        ADD  = 3'b010,
        NAND = 3'b011,
        SHFL = 3'b100,
        OUT  = 3'b101,
        RSV6 = 3'b110,
        RSV7 = 3'b111
    } t_opcode;

    typedef enum logic [1:0] {
        R0  = 2'b00,
        R1  = 2'b01,
        R2  = 2'b10,
        IMM = 2'b11
    } t_reg_name;

    typedef enum logic {
        SRC_REG = 1'b0,
        SRC_IMM = 1'b1
    } t_ALUsrc_ctrl;

    function automatic logic writes_dst(input t_opcode op);
        return (op == LD) || (op == ADD) || (op == NAND) || (op == SHFL);
    endfunction

    function automatic logic reads_src1(input t_opcode op, input t_reg_name s1);
        return ((op == ADD) || (op == NAND) || (op == SHFL) || (op == OUT)) && (s1 != IMM);
    endfunction

    function automatic logic reads_src2(input t_opcode op);
        return (op == ADD) || (op == NAND) || (op == SHFL);
    endfunction

    function automatic logic is_legal(input t_opcode op, input t_reg_name s1, input t_reg_name s2);
        logic ok;
        ok = 1'b1;
        if (op == RSV6 || op == RSV7)
            ok = 1'b0;
        if (op == LD && s1 != IMM)
            ok = 1'b0;
        if (writes_dst(op) && s2 == IMM)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/pipeline_controller_hazard.sv
// rtl/pipeline_controller_hazard.sv - E/W destination scoreboard and RAW stall detection
import definitions::*;

module hazard_unit (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    input  logic      accept,
    input  logic      instv,
    input  t_opcode   opcode,
    input  t_reg_name src1,
    input  t_reg_name src2,
    output logic      stalled
);

    logic      e_valid;
    t_reg_name e_dst;
    logic      w_valid;
    t_reg_name w_dst;
    logic      hit1;
    logic      hit2;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            e_valid <= 1'b0;
            e_dst   <= R0;
            w_valid <= 1'b0;
            w_dst   <= R0;
        end else begin
            w_valid <= e_valid;
            w_dst   <= e_dst;
            e_valid <= accept && writes_dst(opcode);
            e_dst   <= src2;
        end
    end

    // The regfile has no write-through, so a producer blocks readers until it leaves W.
    always_comb begin
        hit1 = reads_src1(opcode, src1) &&
               ((e_valid && e_dst == src1) || (w_valid && w_dst == src1));
        hit2 = reads_src2(opcode) &&
               ((e_valid && e_dst == src2) || (w_valid && w_dst == src2));
        stalled = !reset && instv && is_legal(opcode, src1, src2) && (hit1 || hit2);
    end

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - decode stage driving E-stage ALU controls and W-stage write enable
import definitions::*;

module pipeline_controller (
    input  logic         clock,
    input  logic         reset,
    input  t_opcode      opcode,
    input  logic         instv,
    input  t_reg_name    src1,
    input  t_reg_name    src2,
    output logic         internal_reset,
    output t_ALUsrc_ctrl ALUsrc1,
    output t_ALUsrc_ctrl ALUsrc2,
    output t_opcode      ALUop,
    output logic         wr_en,
    output logic         dataoutv,
    output logic         stalled
);

    logic legal;
    logic illegal;
    logic accept;
    logic e_wr;

    assign legal   = is_legal(opcode, src1, src2);
    assign illegal = instv && !legal;
    assign accept  = instv && legal && !stalled;

    hazard_unit u_hazard (
        .clock   (clock),
        .reset   (reset),
        .flush   (illegal),
        .accept  (accept),
        .instv   (instv),
        .opcode  (opcode),
        .src1    (src1),
        .src2    (src2),
        .stalled (stalled)
    );

    // An illegal instruction only flushes the scoreboard; already-issued outputs keep draining.
    always_ff @(posedge clock) begin
        if (reset) begin
            internal_reset <= 1'b1;
            ALUop          <= NOP;
            ALUsrc1        <= SRC_REG;
            ALUsrc2        <= SRC_REG;
            dataoutv       <= 1'b0;
            e_wr           <= 1'b0;
            wr_en          <= 1'b0;
        end else begin
            internal_reset <= illegal;
            wr_en          <= e_wr;
            if (accept) begin
                ALUop    <= opcode;
                ALUsrc1  <= (src1 == IMM) ? SRC_IMM : SRC_REG;
                ALUsrc2  <= (src2 == IMM) ? SRC_IMM : SRC_REG;
                dataoutv <= (opcode == OUT);
                e_wr     <= writes_dst(opcode);
            end else begin
                ALUop    <= NOP;
                ALUsrc1  <= SRC_REG;
                ALUsrc2  <= SRC_REG;
                dataoutv <= 1'b0;
                e_wr     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
import definitions::*;

module tb_pipeline_controller;

    logic         clock;
    logic         reset;
    t_opcode      opcode;
    logic         instv;
    t_reg_name    src1;
    t_reg_name    src2;
    logic         internal_reset;
    t_ALUsrc_ctrl ALUsrc1;
    t_ALUsrc_ctrl ALUsrc2;
    t_opcode      ALUop;
    logic         wr_en;
    logic         dataoutv;
    logic         stalled;

    int errors;
    int checks;

    pipeline_controller dut (
        .clock          (clock),
        .reset          (reset),
        .opcode         (opcode),
        .instv          (instv),
        .src1           (src1),
        .src2           (src2),
        .internal_reset (internal_reset),
        .ALUsrc1        (ALUsrc1),
        .ALUsrc2        (ALUsrc2),
        .ALUop          (ALUop),
        .wr_en          (wr_en),
        .dataoutv       (dataoutv),
        .stalled        (stalled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input t_opcode op, input logic v, input t_reg_name s1, input t_reg_name s2);
        opcode = op;
        instv  = v;
        src1   = s1;
        src2   = s2;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(NOP, 1'b0, R0, R0);
        step();
        checks++; if (internal_reset !== 1'b1) begin errors++; $display("FAIL reset_ir got=%b exp=1", internal_reset); end
        checks++; if (ALUop !== NOP) begin errors++; $display("FAIL reset_aluop got=%0d exp=%0d", ALUop, NOP); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (dataoutv !== 1'b0) begin errors++; $display("FAIL reset_dataoutv got=%b exp=0", dataoutv); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled got=%b exp=0", stalled); end
        reset = 1'b0;
        step();
        checks++; if (internal_reset !== 1'b0) begin errors++; $display("FAIL reset_release_ir got=%b exp=0", internal_reset); end
    endtask

    task automatic test_bubble();
        drive(LD, 1'b0, R0, R0);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL bubble_stalled got=%b exp=0", stalled); end
        step();
        checks++; if (ALUop !== NOP) begin errors++; $display("FAIL bubble_aluop got=%0d exp=%0d", ALUop, NOP); end
        checks++; if (internal_reset !== 1'b0) begin errors++; $display("FAIL bubble_ir got=%b exp=0", internal_reset); end
    endtask

    task automatic test_illegal();
        drive(LD, 1'b1, R0, R1);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL illegal_ld_stalled got=%b exp=0", stalled); end
        step();
        checks++; if (internal_reset !== 1'b1) begin errors++; $display("FAIL illegal_ld_ir got=%b exp=1", internal_reset); end
        checks++; if (ALUop !== NOP) begin errors++; $display("FAIL illegal_ld_aluop got=%0d exp=%0d", ALUop, NOP); end
        drive(NOP, 1'b0, R0, R0);
        step();
        checks++; if (internal_reset !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end got=%b exp=0", internal_reset); end
        drive(RSV6, 1'b1, IMM, R0);
        step();
        checks++; if (internal_reset !== 1'b1) begin errors++; $display("FAIL illegal_rsv_ir got=%b exp=1", internal_reset); end
        drive(ADD, 1'b1, R0, IMM);
        step();
        checks++; if (internal_reset !== 1'b1) begin errors++; $display("FAIL illegal_dstimm_ir got=%b exp=1", internal_reset); end
        checks++; if (ALUop !== NOP) begin errors++; $display("FAIL illegal_dstimm_aluop got=%0d exp=%0d", ALUop, NOP); end
        drive(NOP, 1'b0, R0, R0);
        step();
    endtask

    task automatic test_back_to_back();
        drive(LD, 1'b1, IMM, R1);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL ld_stalled got=%b exp=0", stalled); end
        step();
        checks++; if (ALUop !== LD) begin errors++; $display("FAIL ld_aluop got=%0d exp=%0d", ALUop, LD); end
        checks++; if (ALUsrc1 !== SRC_IMM) begin errors++; $display("FAIL ld_src1 got=%0d exp=1", ALUsrc1); end
        checks++; if (ALUsrc2 !== SRC_REG) begin errors++; $display("FAIL ld_src2 got=%0d exp=0", ALUsrc2); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ld_wr_early got=%b exp=0", wr_en); end
        drive(ADD, 1'b1, R1, R2);
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL raw_stall1 got=%b exp=1", stalled); end
        step();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL ld_wr_en got=%b exp=1", wr_en); end
        checks++; if (ALUop !== NOP) begin errors++; $display("FAIL raw_bubble got=%0d exp=%0d", ALUop, NOP); end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL raw_stall2 got=%b exp=1", stalled); end
        step();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ld_wr_once got=%b exp=0", wr_en); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL raw_release got=%b exp=0", stalled); end
        step();
        checks++; if (ALUop !== ADD) begin errors++; $display("FAIL add_aluop got=%0d exp=%0d", ALUop, ADD); end
        checks++; if (ALUsrc1 !== SRC_REG) begin errors++; $display("FAIL add_src1 got=%0d exp=0", ALUsrc1); end
        drive(NOP, 1'b0, R0, R0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL add_wr_early got=%b exp=0", wr_en); end
        step();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL add_wr_en got=%b exp=1", wr_en); end
        step();
    endtask

    task automatic test_out();
        drive(NOP, 1'b0, R0, R0);
        for (int i = 0; i < 3; i++) step();
        drive(OUT, 1'b1, R2, R0);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL out_stalled got=%b exp=0", stalled); end
        step();
        checks++; if (dataoutv !== 1'b1) begin errors++; $display("FAIL out_dataoutv got=%b exp=1", dataoutv); end
        checks++; if (ALUop !== OUT) begin errors++; $display("FAIL out_aluop got=%0d exp=%0d", ALUop, OUT); end
        drive(NOP, 1'b0, R0, R0);
        step();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL out_wr_en got=%b exp=0", wr_en); end
        checks++; if (dataoutv !== 1'b0) begin errors++; $display("FAIL out_dataoutv_end got=%b exp=0", dataoutv); end
        step();
    endtask

    task automatic test_gap();
        drive(SHFL, 1'b1, R0, R1);
        step();
        drive(NOP, 1'b0, R0, R0);
        step();
        drive(NAND, 1'b1, R1, R2);
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL gap_dep_stall got=%b exp=1", stalled); end
        step();
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL gap_dep_release got=%b exp=0", stalled); end
        step();
        checks++; if (ALUop !== NAND) begin errors++; $display("FAIL gap_nand_aluop got=%0d exp=%0d", ALUop, NAND); end
        drive(NOP, 1'b0, R0, R0);
        step();
        step();
        drive(SHFL, 1'b1, R0, R1);
        step();
        drive(NOP, 1'b0, R0, R0);
        step();
        drive(NAND, 1'b1, R0, R2);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL gap_indep_stall got=%b exp=0", stalled); end
        step();
        checks++; if (ALUop !== NAND) begin errors++; $display("FAIL gap_indep_aluop got=%0d exp=%0d", ALUop, NAND); end
        drive(SHFL, 1'b1, IMM, R0);
        step();
        drive(NOP, 1'b0, R0, R0);
        step();
        step();
        drive(ADD, 1'b1, R0, R1);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL gap2_stall got=%b exp=0", stalled); end
        step();
        drive(NOP, 1'b0, R0, R0);
        step();
        step();
    endtask

    task automatic test_illegal_flush();
        drive(LD, 1'b1, IMM, R1);
        step();
        drive(RSV7, 1'b1, R0, R0);
        step();
        checks++; if (internal_reset !== 1'b1) begin errors++; $display("FAIL flush_ir got=%b exp=1", internal_reset); end
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL flush_drain_wr got=%b exp=1", wr_en); end
        drive(ADD, 1'b1, R1, R2);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL flush_sb_cleared got=%b exp=0", stalled); end
        step();
        checks++; if (ALUop !== ADD) begin errors++; $display("FAIL flush_add_aluop got=%0d exp=%0d", ALUop, ADD); end
        drive(NOP, 1'b0, R0, R0);
        step();
        step();
    endtask

    task automatic test_reset_mid();
        drive(LD, 1'b1, IMM, R0);
        step();
        reset = 1'b1;
        drive(ADD, 1'b1, R0, R1);
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL mid_reset_stalled got=%b exp=0", stalled); end
        step();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr0 got=%b exp=0", wr_en); end
        checks++; if (ALUop !== NOP) begin errors++; $display("FAIL mid_reset_aluop got=%0d exp=%0d", ALUop, NOP); end
        reset = 1'b0;
        drive(NOP, 1'b0, R0, R0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr%0d got=%b exp=0", i + 1, wr_en); end
        end
        checks++; if (internal_reset !== 1'b0) begin errors++; $display("FAIL mid_reset_ir_end got=%b exp=0", internal_reset); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        opcode = NOP;
        instv  = 1'b0;
        src1   = R0;
        src2   = R0;
        test_reset();
        test_bubble();
        test_illegal();
        test_back_to_back();
        test_out();
        test_gap();
        test_illegal_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
